// File: rtl/reg_file_wb_pkg.sv
// Shared datapath constants and types for the 16-bit RISC core.
package risc_pkg;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [ADDR_W:0]   cnt_t;
endpackage

// File: rtl/reg_file_wb_if.sv
// Bus between decode/write-back and the register file: read ports, write port, issue/stall.
interface reg_file_wb_if #(
  parameter int unsigned DATA_W = risc_pkg::DATA_W,
  parameter int unsigned ADDR_W = risc_pkg::ADDR_W
);
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] data_in;
  logic              issue_valid;
  logic              issue_load;
  logic [ADDR_W-1:0] issue_dst;
  logic [ADDR_W-1:0] issue_src_a;
  logic [ADDR_W-1:0] issue_src_b;
  logic              stall;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output rd_addr_a, rd_addr_b, wr_en, wr_addr, data_in,
           issue_valid, issue_load, issue_dst, issue_src_a, issue_src_b,
    input  rd_data_a, rd_data_b, stall, pend_cnt
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, wr_en, wr_addr, data_in,
           issue_valid, issue_load, issue_dst, issue_src_a, issue_src_b,
    output rd_data_a, rd_data_b, stall, pend_cnt
  );
endinterface

// File: rtl/reg_file_wb_scoreboard.sv
// Per-register load scoreboard: busy bits, RAW/WAW stall and registered busy count.
module reg_scoreboard #(
  parameter int unsigned ADDR_W  = risc_pkg::ADDR_W,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue_valid,
  input  logic              issue_load,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic [ADDR_W-1:0] issue_src_a,
  input  logic [ADDR_W-1:0] issue_src_b,
  output logic              stall,
  output logic [ADDR_W:0]   pend_cnt
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pend_cnt_q, pend_cnt_d;
  logic             accept;

  // A load retiring this very cycle no longer blocks its consumers.
  function automatic logic hazard(input logic [NREGS-1:0] busy, input logic we,
                                  input logic [ADDR_W-1:0] wa, input logic [ADDR_W-1:0] r);
    return busy[r] && !(we && (wa == r));
  endfunction

  always_comb begin
    stall  = issue_valid && (hazard(busy_q, wr_en, wr_addr, issue_src_a) ||
                             hazard(busy_q, wr_en, wr_addr, issue_src_b) ||
                             hazard(busy_q, wr_en, wr_addr, issue_dst));
    accept = issue_valid && !stall;
  end

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) busy_d[wr_addr] = 1'b0;
    if (accept && issue_load && !(R0_ZERO && (issue_dst == '0))) busy_d[issue_dst] = 1'b1;
    pend_cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      pend_cnt_d = pend_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;
endmodule

// File: rtl/reg_file_wb.sv
// Architectural register file with write-through read bypass and load scoreboard.
module reg_file_wb #(
  parameter int unsigned DATA_W  = risc_pkg::DATA_W,
  parameter int unsigned ADDR_W  = risc_pkg::ADDR_W,
  parameter bit          R0_ZERO = 1'b1
) (
  input logic          clk,
  input logic          rst_n,
  reg_file_wb_if.slave bus
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (bus.wr_en && !(R0_ZERO && (bus.wr_addr == '0))) regs_d[bus.wr_addr] = bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  always_comb begin
    bus.rd_data_a = regs_q[bus.rd_addr_a];
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_a)) bus.rd_data_a = bus.data_in;
    if (R0_ZERO && (bus.rd_addr_a == '0)) bus.rd_data_a = '0;
    bus.rd_data_b = regs_q[bus.rd_addr_b];
    if (bus.wr_en && (bus.wr_addr == bus.rd_addr_b)) bus.rd_data_b = bus.data_in;
    if (R0_ZERO && (bus.rd_addr_b == '0)) bus.rd_data_b = '0;
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (bus.wr_en),
    .wr_addr     (bus.wr_addr),
    .issue_valid (bus.issue_valid),
    .issue_load  (bus.issue_load),
    .issue_dst   (bus.issue_dst),
    .issue_src_a (bus.issue_src_a),
    .issue_src_b (bus.issue_src_b),
    .stall       (bus.stall),
    .pend_cnt    (bus.pend_cnt)
  );
endmodule

// File: tb/tb_reg_file_wb.sv
// Randomized and directed bench for reg_file_wb against a behavioural register/busy model.
module tb_reg_file_wb;
  import risc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reg_file_wb_if bus ();

  reg_file_wb #(
    .DATA_W  (16),
    .ADDR_W  (4),
    .R0_ZERO (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [15:0] step;
    logic [15:0] rd_a;
    logic [15:0] rd_b;
    logic        stall;
    logic [4:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned step_no = 0;

  // Reference model: architectural contents and outstanding-load set.
  word_t m_regs [16];
  bit    m_busy [16];

  function automatic word_t m_read(input reg_idx_t a, input logic we, input reg_idx_t wa, input word_t d);
    if (a == 0) return 16'h0000;
    if (we && wa == a) return d;
    return m_regs[a];
  endfunction

  function automatic bit m_hazard(input reg_idx_t r, input logic we, input reg_idx_t wa);
    return m_busy[r] && !(we && wa == r);
  endfunction

  function automatic int unsigned m_pending();
    int unsigned n = 0;
    for (int i = 0; i < 16; i++) if (m_busy[i]) n++;
    return n;
  endfunction

  task automatic drive(input logic rn, input logic we, input reg_idx_t wa, input word_t d,
                       input reg_idx_t ra, input reg_idx_t rb, input logic iv, input logic il,
                       input reg_idx_t dst, input reg_idx_t sa, input reg_idx_t sb);
    exp_t e;
    bit   stl;
    @(negedge clk);
    rst_n = rn;
    bus.wr_en = we; bus.wr_addr = wa; bus.data_in = d;
    bus.rd_addr_a = ra; bus.rd_addr_b = rb;
    bus.issue_valid = iv; bus.issue_load = il;
    bus.issue_dst = dst; bus.issue_src_a = sa; bus.issue_src_b = sb;
    stl = iv && (m_hazard(sa, we, wa) || m_hazard(sb, we, wa) || m_hazard(dst, we, wa));
    e.step  = 16'(step_no);
    e.rd_a  = m_read(ra, we, wa, d);
    e.rd_b  = m_read(rb, we, wa, d);
    e.stall = stl;
    e.pend  = 5'(m_pending());
    exp_q.push_back(e);
    step_no++;
    // State the upcoming rising edge will establish.
    if (!rn) begin
      for (int i = 0; i < 16; i++) begin m_regs[i] = 16'h0000; m_busy[i] = 1'b0; end
    end else begin
      if (we && wa != 0) m_regs[wa] = d;
      if (we) m_busy[wa] = 1'b0;
      if (iv && !stl && il && dst != 0) m_busy[dst] = 1'b1;
    end
  endtask

  task automatic idle(input reg_idx_t ra, input reg_idx_t rb);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, ra, rb, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
  endtask

  // Monitor: outputs are stable well after the falling edge where inputs change.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (bus.rd_data_a !== e.rd_a) begin
          errors++;
          $display("FAIL rd_data_a step %0d got %h expected %h", e.step, bus.rd_data_a, e.rd_a);
        end
        checks++;
        if (bus.rd_data_b !== e.rd_b) begin
          errors++;
          $display("FAIL rd_data_b step %0d got %h expected %h", e.step, bus.rd_data_b, e.rd_b);
        end
        checks++;
        if (bus.stall !== e.stall) begin
          errors++;
          $display("FAIL stall step %0d got %b expected %b", e.step, bus.stall, e.stall);
        end
        checks++;
        if (bus.pend_cnt !== e.pend) begin
          errors++;
          $display("FAIL pend_cnt step %0d got %0d expected %0d", e.step, bus.pend_cnt, e.pend);
        end
      end
    end
  end

  initial begin
    int unsigned wait_cnt;
    logic we, iv, il, rn;
    reg_idx_t wa;

    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.data_in = '0;
    bus.rd_addr_a = '0; bus.rd_addr_b = '0;
    bus.issue_valid = 1'b0; bus.issue_load = 1'b0;
    bus.issue_dst = '0; bus.issue_src_a = '0; bus.issue_src_b = '0;
    for (int i = 0; i < 16; i++) begin m_regs[i] = 16'h0000; m_busy[i] = 1'b0; end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state across all indices.
    for (int i = 0; i < 8; i++) idle(4'(2*i), 4'(2*i+1));

    // Write-through bypass then array read.
    drive(1'b1, 1'b1, 4'd3, 16'hBEEF, 4'd3, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(4'd3, 4'd3);

    // Register 0 ignores writes.
    drive(1'b1, 1'b1, 4'd0, 16'h1234, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    idle(4'd0, 4'd3);

    // Load on r5: RAW stall, retirement releases stall in the same cycle.
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd0, 1'b1, 1'b1, 4'd5, 4'd1, 4'd2);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 4'd5, 4'd1);
    drive(1'b1, 1'b1, 4'd5, 16'h00A5, 4'd5, 4'd0, 1'b1, 1'b0, 4'd6, 4'd5, 4'd1);
    idle(4'd5, 4'd6);

    // Same-cycle clear and set of r7: set wins.
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b1, 1'b1, 4'd7, 4'd1, 4'd2);
    drive(1'b1, 1'b1, 4'd7, 16'h7777, 4'd7, 4'd0, 1'b1, 1'b1, 4'd7, 4'd1, 4'd2);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd7, 4'd0, 1'b1, 1'b0, 4'd8, 4'd7, 4'd1);
    drive(1'b1, 1'b1, 4'd7, 16'h0707, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    // Reset while r2/r4 loads are outstanding.
    drive(1'b1, 1'b1, 4'd2, 16'h2222, 4'd2, 4'd4, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);
    drive(1'b1, 1'b1, 4'd4, 16'h4444, 4'd2, 4'd4, 1'b1, 1'b1, 4'd2, 4'd1, 4'd3);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 1'b1, 1'b1, 4'd4, 4'd1, 4'd3);
    drive(1'b0, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 1'b1, 1'b0, 4'd6, 4'd2, 4'd4);
    drive(1'b1, 1'b0, 4'd0, 16'h0000, 4'd2, 4'd4, 1'b1, 1'b0, 4'd6, 4'd2, 4'd4);
    drive(1'b1, 1'b1, 4'd4, 16'hCAFE, 4'd4, 4'd2, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0);

    // Random traffic; write-backs favour currently busy registers.
    for (int n = 0; n < 500; n++) begin
      rn = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      we = ($urandom_range(0, 99) < 45);
      wa = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) if (m_busy[(int'(wa) + k) % 16]) begin
          wa = 4'((int'(wa) + k) % 16);
          break;
        end
      end
      iv = ($urandom_range(0, 99) < 70);
      il = ($urandom_range(0, 99) < 50);
      drive(rn, we, wa, 16'($urandom), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            iv, il, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end
    idle(4'd1, 4'd2);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
